// File: rtl/fifo.sv
`default_nettype none
// ============================================================================
//  Module   : fifo
//  Brief    : Single-clock byte FIFO with FULL/EMPTY flags and registered
//             read data; overflow writes and underflow reads are dropped.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4     // power of two, >= 2
) (
    input  logic             SYSCLK,
    input  logic             RST_B,
    input  logic             WR_EN,
    input  logic             RD_EN,
    input  logic [WIDTH-1:0] FIFO_IN,
    output logic             FULL,
    output logic             EMPTY,
    output logic [WIDTH-1:0] FIFO_OUT
);

    localparam int                c_ADDR_W   = $clog2(DEPTH);
    localparam logic [c_ADDR_W:0] c_FULL_CNT = (c_ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_ADDR_W:0]   r_count;
    logic [WIDTH-1:0]    r_fifo_out;
    logic                w_wr_acc;
    logic                w_rd_acc;

    // A write into a full buffer is legal only when a read frees the slot
    // on the same edge.
    always_comb begin
        w_rd_acc = RD_EN && !EMPTY;
        w_wr_acc = WR_EN && (!FULL || w_rd_acc);
    end

    assign FULL     = (r_count == c_FULL_CNT);
    assign EMPTY    = (r_count == '0);
    assign FIFO_OUT = r_fifo_out;

    always_ff @(posedge SYSCLK or negedge RST_B) begin
        if (!RST_B) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_fifo_out <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_fifo_out <= r_mem[r_rd_ptr];
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage is deliberately left unreset; only entries below the count are read.
    always_ff @(posedge SYSCLK) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= FIFO_IN;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo
//  Brief    : Directed self-checking bench for fifo (WIDTH=8, DEPTH=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo;

    logic       SYSCLK;
    logic       RST_B;
    logic       WR_EN;
    logic       RD_EN;
    logic [7:0] FIFO_IN;
    logic       FULL;
    logic       EMPTY;
    logic [7:0] FIFO_OUT;

    int n_vec;
    int n_err;

    fifo #(.WIDTH(8), .DEPTH(4)) dut (
        .SYSCLK   (SYSCLK),
        .RST_B    (RST_B),
        .WR_EN    (WR_EN),
        .RD_EN    (RD_EN),
        .FIFO_IN  (FIFO_IN),
        .FULL     (FULL),
        .EMPTY    (EMPTY),
        .FIFO_OUT (FIFO_OUT)
    );

    initial begin
        SYSCLK = 1'b0;
        forever #5 SYSCLK = ~SYSCLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus and sample 1 time unit after the rising edge.
    task automatic cycle(input logic wr, input logic rd, input logic [7:0] din);
        WR_EN   = wr;
        RD_EN   = rd;
        FIFO_IN = din;
        @(posedge SYSCLK);
        #1;
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        RST_B   = 1'b1;
        WR_EN   = 1'b0;
        RD_EN   = 1'b0;
        FIFO_IN = 8'h00;

        // ---- reset between edges, checked asynchronously ----
        #3 RST_B = 1'b0;
        #1;
        chk("rst_empty", 32'(EMPTY), 32'd1);
        chk("rst_full", 32'(FULL), 32'd0);
        chk("rst_out", 32'(FIFO_OUT), 32'h00);
        @(posedge SYSCLK);
        #3 RST_B = 1'b1;
        @(posedge SYSCLK);
        #1;
        chk("rel_empty", 32'(EMPTY), 32'd1);
        chk("rel_full", 32'(FULL), 32'd0);
        chk("rel_out", 32'(FIFO_OUT), 32'h00);

        // ---- sequence test ----
        cycle(1'b1, 1'b0, 8'd11);
        chk("seq_w11_empty", 32'(EMPTY), 32'd0);
        chk("seq_w11_out", 32'(FIFO_OUT), 32'h00);
        cycle(1'b1, 1'b0, 8'd24);
        chk("seq_w24_empty", 32'(EMPTY), 32'd0);
        cycle(1'b1, 1'b1, 8'd31);
        chk("seq_out11", 32'(FIFO_OUT), 32'd11);
        cycle(1'b1, 1'b1, 8'd46);
        chk("seq_out24", 32'(FIFO_OUT), 32'd24);
        cycle(1'b1, 1'b1, 8'd57);
        chk("seq_out31", 32'(FIFO_OUT), 32'd31);
        chk("seq_full_n", 32'(FULL), 32'd0);
        cycle(1'b0, 1'b1, 8'd0);
        chk("seq_out46", 32'(FIFO_OUT), 32'd46);
        chk("seq_empty_n", 32'(EMPTY), 32'd0);
        cycle(1'b0, 1'b1, 8'd0);
        chk("seq_out57", 32'(FIFO_OUT), 32'd57);
        chk("seq_empty", 32'(EMPTY), 32'd1);
        cycle(1'b0, 1'b1, 8'd0);
        chk("seq_hold57", 32'(FIFO_OUT), 32'd57);
        chk("seq_empty_hold", 32'(EMPTY), 32'd1);

        // ---- overflow ----
        for (int i = 1; i <= 5; i++) begin
            cycle(1'b1, 1'b0, 8'(i));
            chk("ovf_full", 32'(FULL), (i >= 4) ? 32'd1 : 32'd0);
            chk("ovf_empty", 32'(EMPTY), 32'd0);
        end
        chk("ovf_out_hold", 32'(FIFO_OUT), 32'd57);
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b0, 1'b1, 8'd0);
            chk("ovf_rd", 32'(FIFO_OUT), 32'(i));
            chk("ovf_rd_full", 32'(FULL), 32'd0);
            chk("ovf_rd_empty", 32'(EMPTY), (i == 4) ? 32'd1 : 32'd0);
        end

        // ---- underflow ----
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 8'd0);
            chk("udf_out", 32'(FIFO_OUT), 32'd4);
            chk("udf_empty", 32'(EMPTY), 32'd1);
            chk("udf_full", 32'(FULL), 32'd0);
        end
        cycle(1'b1, 1'b0, 8'hA5);
        chk("udf_wr_empty", 32'(EMPTY), 32'd0);
        chk("udf_wr_full", 32'(FULL), 32'd0);
        cycle(1'b0, 1'b1, 8'd0);
        chk("udf_rd_a5", 32'(FIFO_OUT), 32'hA5);
        chk("udf_rd_empty", 32'(EMPTY), 32'd1);

        // ---- full with simultaneous write and read ----
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b1, 1'b0, 8'(i));
        end
        chk("fwr_full", 32'(FULL), 32'd1);
        cycle(1'b1, 1'b1, 8'd9);
        chk("fwr_out1", 32'(FIFO_OUT), 32'd1);
        chk("fwr_full_stay", 32'(FULL), 32'd1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 8'd0);
            chk("fwr_rd", 32'(FIFO_OUT), (i == 3) ? 32'd9 : 32'(i + 2));
            chk("fwr_rd_empty", 32'(EMPTY), (i == 3) ? 32'd1 : 32'd0);
        end

        // ---- streaming across pointer wraps with two entries held ----
        cycle(1'b1, 1'b0, 8'h20);
        cycle(1'b1, 1'b0, 8'h21);
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 1'b1, 8'(8'h22 + i));
            chk("wrap_out", 32'(FIFO_OUT), 32'(8'h20 + i));
            chk("wrap_empty", 32'(EMPTY), 32'd0);
            chk("wrap_full", 32'(FULL), 32'd0);
        end
        cycle(1'b1, 1'b0, 8'h2E);
        chk("wrap_3_full", 32'(FULL), 32'd0);

        // ---- mid-operation reset with three entries stored ----
        #3 RST_B = 1'b0;
        #1;
        chk("mrst_empty", 32'(EMPTY), 32'd1);
        chk("mrst_full", 32'(FULL), 32'd0);
        chk("mrst_out", 32'(FIFO_OUT), 32'h00);
        WR_EN   = 1'b1;
        RD_EN   = 1'b1;
        FIFO_IN = 8'hEE;
        @(posedge SYSCLK);
        #1;
        chk("mrst_hold_empty", 32'(EMPTY), 32'd1);
        chk("mrst_hold_out", 32'(FIFO_OUT), 32'h00);
        WR_EN = 1'b0;
        RD_EN = 1'b0;
        #3 RST_B = 1'b1;
        cycle(1'b1, 1'b0, 8'h77);
        chk("mrst_wr_empty", 32'(EMPTY), 32'd0);
        cycle(1'b0, 1'b1, 8'h00);
        chk("mrst_rd_77", 32'(FIFO_OUT), 32'h77);
        chk("mrst_rd_empty", 32'(EMPTY), 32'd1);
        cycle(1'b0, 1'b0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo.md
# fifo

Synchronous single-clock first-in/first-out buffer, 8 bits wide and 4 entries deep by default. It decouples a byte producer from a byte consumer in the same clock domain. It reports FULL and EMPTY status. Writes into a full buffer and reads from an empty buffer are ignored safely: no data corruption, no pointer movement.

## Interface
- WIDTH, default 8: data word width in bits.
- DEPTH, default 4: number of storage entries. Must be a power of two and at least 2.
- Port order is positional, exactly as listed below.
- SYSCLK  in  1  system clock. All state changes on the rising edge.
- RST_B  in  1  reset. One clock; reset is asynchronous and active-low.
- WR_EN  in  1  write request. Samples FIFO_IN on the rising edge.
- RD_EN  in  1  read request. Pops the oldest entry into FIFO_OUT on the rising edge.
- FIFO_IN  in  WIDTH  write data.
- FULL  out  1  high when DEPTH entries are stored.
- EMPTY  out  1  high when no entries are stored.
- FIFO_OUT  out  WIDTH  registered read data. Holds the last popped word.

## Operation
- State:
  - storage array of DEPTH × WIDTH;
  - write pointer and read pointer, each log2(DEPTH) bits, wrapping modulo DEPTH;
  - occupancy count, 0..DEPTH, log2(DEPTH)+1 bits.
- Write accepted when WR_EN=1 and (FULL=0 or read accepted in the same cycle).
  - FIFO_IN is stored at the write pointer, which then increments.
  - A write while FULL=1 without an accepted read is dropped. Storage, pointers and count are unchanged.
- Read accepted when RD_EN=1 and EMPTY=0.
  - The entry at the read pointer is loaded into FIFO_OUT and the read pointer increments.
  - A read while EMPTY=1 is dropped, and FIFO_OUT holds its value.
- Count update: +1 on write only, −1 on read only, unchanged on both or neither.
- Simultaneous write and read when EMPTY=1: only the write is accepted.
- Simultaneous write and read when FULL=1: both are accepted and the count stays at DEPTH.
- FULL = (count == DEPTH). EMPTY = (count == 0). Both are decoded from registered count with no extra register stage.
- Storage contents are not reset. Only valid entries are ever read.

## Timing
- Reset (RST_B low, asynchronous, any time including mid-transfer):
  - pointers = 0, count = 0, FIFO_OUT = 0;
  - EMPTY = 1, FULL = 0 immediately.
- While RST_B is low, WR_EN and RD_EN are ignored.
- The first edge after RST_B rises operates normally.
- Write-to-flag latency: the flags reflect a write/read after the same rising edge that performed it.
- Read latency is one cycle. The word appears on FIFO_OUT after the rising edge where RD_EN=1 was accepted, and is stable until the next accepted read or reset.
- Write-to-read latency: a word written at edge N can be read at edge N+1 at the earliest.
- Throughput: one write and one read per cycle sustained.
- Pointer wrap: after entry DEPTH−1 the pointer returns to 0 with no bubble.

## Test plan
- Reset: assert RST_B=0 between clock edges. Required: EMPTY=1, FULL=0, FIFO_OUT=0 asynchronously, and after release.
- Sequence test (one value per cycle):
  - Write 11, 24.
  - Then write 31, 46, 57 with RD_EN=1 concurrently.
  - Then WR_EN=0 with RD_EN=1 for 3 more cycles.
  - Required: FIFO_OUT shows 11, 24, 31, 46, 57, then holds 57.
  - EMPTY rises after the read of 57. The final read is dropped.
- Overflow: write 1, 2, 3, 4, 5 with RD_EN=0.
  - Required: FULL=1 after the 4th write, and the 5th write is dropped.
  - Four reads then return 1, 2, 3, 4, and EMPTY=1.
- Underflow: RD_EN=1 on an empty FIFO for 3 cycles.
  - Required: FIFO_OUT is unchanged, EMPTY stays 1, and the count does not go negative.
  - A subsequent write of 0xA5 followed by a read returns 0xA5.
- Full with simultaneous write and read: fill with 1..4, then WR_EN=RD_EN=1 with FIFO_IN=9.
  - Required: FIFO_OUT=1 and FULL stays 1.
  - Later reads return 2, 3, 4, 9.
- Wrap plus mid-operation reset:
  - Stream 12 words with 2 entries occupied. The data order must be preserved across pointer wraps.
  - Then assert RST_B with 3 entries stored. Required: EMPTY=1 immediately, and the next write/read pair returns the newly written word.
